fcvt_f2i_pipe: RTL

//  Pipelined IEEE-754 single -> signed/unsigned integer converter (FCVT.W/WU, .L/.LU).

---
 rtl/fcvt_pkg.sv | 36 +++
 rtl/fcvt_round_inc.sv | 25 ++
 rtl/fcvt_f2i_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/fcvt_pkg.sv
// Shared types and FP32 field constants for the float-to-integer converter.
package fcvt_pkg;

  typedef enum logic [2:0] {
    RNE = 3'b000,
    RTZ = 3'b001,
    RDN = 3'b010,
    RUP = 3'b011,
    RMM = 3'b100
  } rm_e;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
    logic sub;
  } fp_class_t;

  localparam int EXP_BIAS = 127;
  localparam int MANT_W   = 23;
  localparam int EXP_W    = 8;

  // Reserved encodings fall back to round-to-nearest-even.
  function automatic rm_e rm_decode(input logic [2:0] raw);
    rm_e rm;
    case (raw)
      3'b001:  rm = RTZ;
      3'b010:  rm = RDN;
      3'b011:  rm = RUP;
      3'b100:  rm = RMM;
      default: rm = RNE;
    endcase
    return rm;
  endfunction

endpackage

// File: rtl/fcvt_round_inc.sv
// Rounding decision: whether to add one ulp to the truncated magnitude.
module fcvt_round_inc
  import fcvt_pkg::*;
(
  input  logic lsb,
  input  logic guard,
  input  logic sticky,
  input  logic sign,
  input  rm_e  rm,
  output logic inc
);

  always_comb begin
    inc = 1'b0;
    case (rm)
      RNE:     inc = guard & (sticky | lsb);
      RTZ:     inc = 1'b0;
      RDN:     inc = sign & (guard | sticky);
      RUP:     inc = ~sign & (guard | sticky);
      RMM:     inc = guard;
      default: inc = guard & (sticky | lsb);
    endcase
  end

endmodule

// File: rtl/fcvt_f2i_pipe.sv
// 3-stage FP32 -> signed/unsigned integer converter with valid/ready back-pressure.
// Sticky {NV,NX} accumulation is built only when FCVT_F2I_FLAGS_EN is defined.
module fcvt_f2i_pipe
  import fcvt_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_num,
  input  logic [2:0]       in_rm,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_int,
  output logic             out_nv,
  output logic             out_nx,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flags_clr,
  output logic [1:0]       fflags_o
);

  // Fixed point: INT_W integer bits, one guard bit, 24 sticky bits.
  localparam int AW = INT_W + 25;
  localparam logic signed [9:0] INT_W_S = 10'(INT_W);
  localparam logic [INT_W-1:0] MAX_POS = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] MIN_NEG = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W:0]   NEG_LIM = {2'b01, {(INT_W-1){1'b0}}};

  logic s1_valid, s2_valid;
  logic s1_adv, s2_adv, s3_ready;

  assign s3_ready = ~out_valid | out_ready;
  assign s2_adv   = s2_valid & s3_ready;
  assign s1_adv   = s1_valid & (~s2_valid | s2_adv);
  assign in_ready = ~s1_valid | s1_adv;

  // ---------------- S1: unpack and classify ----------------
  fp_class_t              in_cls, s1_cls;
  logic                   s1_sign, s1_uns;
  logic [EXP_W-1:0]       s1_exp;
  logic [MANT_W-1:0]      s1_frac;
  rm_e                    s1_rm;
  logic [TAG_W-1:0]       s1_tag;

  always_comb begin
    in_cls.nan  = (in_num[30:23] == 8'hFF) & (in_num[22:0] != '0);
    in_cls.inf  = (in_num[30:23] == 8'hFF) & (in_num[22:0] == '0);
    in_cls.zero = (in_num[30:23] == 8'h00) & (in_num[22:0] == '0);
    in_cls.sub  = (in_num[30:23] == 8'h00) & (in_num[22:0] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_frac  <= '0;
      s1_cls   <= '0;
      s1_rm    <= RNE;
      s1_uns   <= 1'b0;
      s1_tag   <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign <= in_num[31];
        s1_exp  <= in_num[30:23];
        s1_frac <= in_num[22:0];
        s1_cls  <= in_cls;
        s1_rm   <= rm_decode(in_rm);
        s1_uns  <= in_unsigned;
        s1_tag  <= in_tag;
      end
    end
  end

  // ---------------- S2: align and round ----------------
  logic signed [9:0] e_unb;
  logic [AW-1:0]     base, aligned;
  logic [INT_W-1:0]  int_part;
  logic              guard, sticky, big, inc;
  logic [INT_W:0]    mag;

  assign e_unb = $signed({2'b00, s1_exp}) - 10'sd127;

  always_comb begin
    base        = '0;
    base[25:2]  = {1'b1, s1_frac};
    aligned     = '0;
    int_part    = '0;
    guard       = 1'b0;
    sticky      = 1'b0;
    big         = 1'b0;
    if (s1_cls.nan || s1_cls.inf) begin
      big = 1'b1;
    end else if (s1_cls.zero) begin
      sticky = 1'b0;
    end else if (s1_cls.sub) begin
      sticky = 1'b1;
    end else if (e_unb >= INT_W_S) begin
      big = 1'b1;
    end else if (e_unb >= 10'sd0) begin
      aligned  = base << e_unb[6:0];
      int_part = aligned[AW-1:25];
      guard    = aligned[24];
      sticky   = |aligned[23:0];
    end else if (e_unb == -10'sd1) begin
      guard  = 1'b1;
      sticky = |s1_frac;
    end else begin
      sticky = 1'b1;
    end
  end

  fcvt_round_inc u_round (
    .lsb    (int_part[0]),
    .guard  (guard),
    .sticky (sticky),
    .sign   (s1_sign),
    .rm     (s1_rm),
    .inc    (inc)
  );

  assign mag = {1'b0, int_part} + {{INT_W{1'b0}}, inc};

  logic             s2_sign, s2_nan, s2_big, s2_inx, s2_uns;
  logic [INT_W:0]   s2_mag;
  logic [TAG_W-1:0] s2_tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_sign  <= 1'b0;
      s2_nan   <= 1'b0;
      s2_big   <= 1'b0;
      s2_inx   <= 1'b0;
      s2_uns   <= 1'b0;
      s2_mag   <= '0;
      s2_tag   <= '0;
    end else begin
      if (~s2_valid | s2_adv) s2_valid <= s1_valid;
      if (s1_adv) begin
        s2_sign <= s1_sign;
        s2_nan  <= s1_cls.nan;
        s2_big  <= big;
        s2_inx  <= guard | sticky;
        s2_uns  <= s1_uns;
        s2_mag  <= mag;
        s2_tag  <= s1_tag;
      end
    end
  end

  // ---------------- S3: range check, saturate, negate ----------------
  logic [INT_W-1:0] res;
  logic             nv, nx;

  always_comb begin
    res = '0;
    nv  = 1'b0;
    nx  = 1'b0;
    if (s2_nan) begin
      nv  = 1'b1;
      res = s2_uns ? '1 : MAX_POS;
    end else if (s2_uns) begin
      if (s2_sign) begin
        if (s2_big || s2_mag != '0) nv = 1'b1;
        else                        nx = s2_inx;
      end else if (s2_big || s2_mag[INT_W]) begin
        nv  = 1'b1;
        res = '1;
      end else begin
        res = s2_mag[INT_W-1:0];
        nx  = s2_inx;
      end
    end else if (s2_sign) begin
      // Magnitude exactly 2^(INT_W-1) is the most negative integer, still in range.
      if (s2_big || s2_mag > NEG_LIM) begin
        nv  = 1'b1;
        res = MIN_NEG;
      end else begin
        res = -s2_mag[INT_W-1:0];
        nx  = s2_inx;
      end
    end else if (s2_big || s2_mag[INT_W] || s2_mag[INT_W-1]) begin
      nv  = 1'b1;
      res = MAX_POS;
    end else begin
      res = s2_mag[INT_W-1:0];
      nx  = s2_inx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_int   <= '0;
      out_nv    <= 1'b0;
      out_nx    <= 1'b0;
      out_tag   <= '0;
    end else begin
      if (s3_ready) out_valid <= s2_valid;
      if (s2_adv) begin
        out_int <= res;
        out_nv  <= nv;
        out_nx  <= nx;
        out_tag <= s2_tag;
      end
    end
  end

`ifdef FCVT_F2I_FLAGS_EN
  logic out_xfer;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fflags_o <= 2'b00;
    end else if (out_xfer) begin
      fflags_o <= (flags_clr ? 2'b00 : fflags_o) | {out_nv, out_nx};
    end else if (flags_clr) begin
      fflags_o <= 2'b00;
    end
  end
`else
  logic unused_flags_clr;
  assign unused_flags_clr = flags_clr;
  assign fflags_o = 2'b00;
`endif

endmodule
